ddr_traffic_checker: RTL and testbench

// Parametrised write/read-back traffic generator and checker for the MIG DDR controller user side.

---
 rtl/ddr_tc_pkg.sv | 50 +++++
 rtl/ddr_pat_gen.sv | 68 ++++++
 rtl/ddr_traffic_checker.sv | 159 +++++++++++++++
 tb/tb_ddr_traffic_checker.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_tc_pkg.sv
// Shared definitions for the DDR write/read-back traffic checker.
// Contents: data pattern mode encodings, checker FSM states, burst phase,
// PRBS31 (x^31 + x^28 + 1) taps and seed, and a 32-bit-per-call LFSR step.
package ddr_tc_pkg;

   typedef enum logic [1:0] {
      MODE_COUNT     = 2'd0,
      MODE_PRBS31    = 2'd1,
      MODE_WALK1     = 2'd2,
      MODE_INV_COUNT = 2'd3
   } mode_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_WRITE,
      ST_READ,
      ST_DONE
   } state_t;

   typedef enum logic {
      PH_WR = 1'b0,
      PH_RD = 1'b1
   } phase_t;

   localparam logic [30:0] PRBS_SEED   = 31'h1;
   localparam int          PRBS_TAP_HI = 30;  // x^31 term
   localparam int          PRBS_TAP_LO = 27;  // x^28 term

   typedef struct packed {
      logic [30:0] state;
      logic [31:0] word;
   } prbs_t;

   // Runs the Fibonacci LFSR 32 times. The first generated bit lands in
   // word[31], the last in word[0]; state is the register after the 32 steps.
   function automatic prbs_t prbs_step32(input logic [30:0] s);
      prbs_t r;
      logic  b;
      r.state = s;
      r.word  = '0;
      for (int i = 0; i < 32; i++) begin
         b       = r.state[PRBS_TAP_HI] ^ r.state[PRBS_TAP_LO];
         r.word  = {r.word[30:0], b};
         r.state = {r.state[29:0], b};
      end
      return r;
   endfunction

endpackage

// File: rtl/ddr_pat_gen.sv
// Beat pattern generator: produces a registered beat value for the selected
// pattern. seed_load restarts at beat 0; advance steps to the next beat.
// Ports:
//   clk, rst   clock and async active-high reset
//   mode       pattern selection (COUNT, PRBS31, WALK1, INV_COUNT)
//   seed_load  restart sequence; data holds beat 0 the following cycle
//   advance    step to the next beat (seed_load takes priority)
//   data       current beat value, DATA_W bits
module ddr_pat_gen
   import ddr_tc_pkg::*;
#(
   parameter int DATA_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  mode_t             mode,
   input  logic              seed_load,
   input  logic              advance,
   output logic [DATA_W-1:0] data
);

   localparam int WW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic [7:0]    cnt, cnt_nxt;
   logic [WW-1:0] walk, walk_nxt;
   logic [30:0]   lfsr;
   prbs_t         prbs_nxt;

   function automatic logic [DATA_W-1:0] pattern(input mode_t m, input logic [7:0] c,
                                                 input logic [WW-1:0] w, input logic [31:0] pw);
      logic [DATA_W-1:0] p;
      case (m)
         MODE_COUNT:     p = {(DATA_W/8){c}};
         MODE_INV_COUNT: p = ~{(DATA_W/8){c}};
         MODE_WALK1:     p = {{(DATA_W-1){1'b0}}, 1'b1} << w;
         default:        p = {(DATA_W/32){pw}};
      endcase
      return p;
   endfunction

   // walk tracks k mod DATA_W separately so DATA_W need not be a power of two
   always_comb begin
      if (seed_load) begin
         cnt_nxt  = '0;
         walk_nxt = '0;
         prbs_nxt = prbs_step32(PRBS_SEED);
      end else begin
         cnt_nxt  = cnt + 8'd1;
         walk_nxt = (walk == WW'(DATA_W-1)) ? '0 : walk + 1'b1;
         prbs_nxt = prbs_step32(lfsr);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         walk <= '0;
         lfsr <= PRBS_SEED;
         data <= '0;
      end else if (seed_load || advance) begin
         cnt  <= cnt_nxt;
         walk <= walk_nxt;
         lfsr <= prbs_nxt.state;
         data <= pattern(mode, cnt_nxt, walk_nxt, prbs_nxt.word);
      end
   end

endmodule

// File: rtl/ddr_traffic_checker.sv
// Write/read-back traffic generator and checker for the MIG user interface.
// Each loop issues one write burst then one read burst of BURST_LEN beats and
// compares read data with an independently regenerated pattern.
// Ports:
//   ui_clk, rst            user clock, async active-high reset
//   cfg_start/mode/loops   run request (accepted only in IDLE or DONE)
//   ddr_busy               controller busy; blocks burst requests
//   wr_start, data_req, wr_ddr_data, wr_done   write burst handshake
//   rd_start, rd_data_vld, rd_ddr_data, rd_done read burst handshake
//   busy, done, error, err_cnt, first_err_beat, len_err, pass_cnt   status
module ddr_traffic_checker
   import ddr_tc_pkg::*;
#(
   parameter int DATA_W    = 256,
   parameter int BURST_LEN = 64,
   parameter int ERRCNT_W  = 16,
   parameter int LOOP_W    = 16
) (
   input  logic                         ui_clk,
   input  logic                         rst,
   input  logic                         cfg_start,
   input  logic [1:0]                   cfg_mode,
   input  logic [LOOP_W-1:0]            cfg_loops,
   input  logic                         ddr_busy,
   output logic                         wr_start,
   input  logic                         data_req,
   output logic [DATA_W-1:0]            wr_ddr_data,
   input  logic                         wr_done,
   output logic                         rd_start,
   input  logic                         rd_data_vld,
   input  logic [DATA_W-1:0]            rd_ddr_data,
   input  logic                         rd_done,
   output logic                         busy,
   output logic                         done,
   output logic                         error,
   output logic [ERRCNT_W-1:0]          err_cnt,
   output logic [$clog2(BURST_LEN)-1:0] first_err_beat,
   output logic                         len_err,
   output logic [LOOP_W-1:0]            pass_cnt
);

   localparam int BW = $clog2(BURST_LEN);
   // one extra bit so a full burst does not alias to zero beats
   localparam int CW = $clog2(BURST_LEN + 1);

   state_t            state;
   phase_t            phase;
   mode_t             mode;
   logic [LOOP_W-1:0] loops, loop_cnt, loop_cnt_nxt;
   logic [CW-1:0]     rd_beats, rd_total;
   logic              loop_err;
   logic [DATA_W-1:0] rd_exp;
   logic              issue, wr_issue, rd_issue, rd_beat, mismatch, short_burst;

   assign issue        = (state == ST_ARB) && !ddr_busy;
   assign wr_issue     = issue && (phase == PH_WR);
   assign rd_issue     = issue && (phase == PH_RD);
   assign rd_beat      = (state == ST_READ) && rd_data_vld;
   assign mismatch     = rd_beat && (rd_ddr_data != rd_exp);
   assign rd_total     = rd_beats + (rd_beat ? CW'(1) : CW'(0));
   assign short_burst  = (rd_total != CW'(BURST_LEN));
   assign loop_cnt_nxt = loop_cnt + 1'b1;

   ddr_pat_gen #(.DATA_W(DATA_W)) u_wr_gen (
      .clk(ui_clk), .rst(rst), .mode(mode),
      .seed_load(wr_issue), .advance(data_req), .data(wr_ddr_data)
   );

   ddr_pat_gen #(.DATA_W(DATA_W)) u_rd_gen (
      .clk(ui_clk), .rst(rst), .mode(mode),
      .seed_load(rd_issue), .advance(rd_beat), .data(rd_exp)
   );

   always_ff @(posedge ui_clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         phase          <= PH_WR;
         mode           <= MODE_COUNT;
         loops          <= '0;
         loop_cnt       <= '0;
         rd_beats       <= '0;
         loop_err       <= 1'b0;
         wr_start       <= 1'b0;
         rd_start       <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
         err_cnt        <= '0;
         first_err_beat <= '0;
         len_err        <= 1'b0;
         pass_cnt       <= '0;
      end else begin
         wr_start <= wr_issue;
         rd_start <= rd_issue;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (cfg_start) begin
                  state          <= ST_ARB;
                  phase          <= PH_WR;
                  mode           <= mode_t'(cfg_mode);
                  loops          <= cfg_loops;
                  loop_cnt       <= '0;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  error          <= 1'b0;
                  err_cnt        <= '0;
                  first_err_beat <= '0;
                  len_err        <= 1'b0;
                  pass_cnt       <= '0;
               end
            end
            ST_ARB: begin
               if (wr_issue) begin
                  state    <= ST_WRITE;
                  loop_err <= 1'b0;
               end else if (rd_issue) begin
                  state    <= ST_READ;
                  rd_beats <= '0;
               end
            end
            ST_WRITE: begin
               if (wr_done) begin
                  state <= ST_ARB;
                  phase <= PH_RD;
               end
            end
            ST_READ: begin
               if (rd_beat) begin
                  rd_beats <= rd_total;
                  if (mismatch) begin
                     error    <= 1'b1;
                     loop_err <= 1'b1;
                     if (!error) first_err_beat <= rd_beats[BW-1:0];
                     if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                  end
               end
               if (rd_done) begin
                  if (short_burst) begin
                     len_err <= 1'b1;
                     error   <= 1'b1;
                  end
                  if (!loop_err && !mismatch && !short_burst) pass_cnt <= pass_cnt + 1'b1;
                  loop_cnt <= loop_cnt_nxt;
                  phase    <= PH_WR;
                  if ((loops != '0) && (loop_cnt_nxt == loops)) begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_ARB;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_traffic_checker.sv
// Directed testbench for ddr_traffic_checker. Emulates a loopback DDR
// controller: write beats are stored in mem and returned on the read burst,
// optionally corrupted or shortened.
module tb_ddr_traffic_checker;

   localparam int DW = 256;
   localparam int BL = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_start = 1'b0;
   logic [1:0]    cfg_mode = 2'd0;
   logic [15:0]   cfg_loops = '0;
   logic          ddr_busy = 1'b0;
   logic          wr_start;
   logic          data_req = 1'b0;
   logic [DW-1:0] wr_ddr_data;
   logic          wr_done = 1'b0;
   logic          rd_start;
   logic          rd_data_vld = 1'b0;
   logic [DW-1:0] rd_ddr_data = '0;
   logic          rd_done = 1'b0;
   logic          busy, done, error, len_err;
   logic [15:0]   err_cnt, pass_cnt;
   logic [5:0]    first_err_beat;

   logic [DW-1:0] mem [0:BL-1];
   logic [DW-1:0] one = 1;
   int            checks = 0;
   int            errors = 0;

   ddr_traffic_checker #(.DATA_W(DW), .BURST_LEN(BL), .ERRCNT_W(16), .LOOP_W(16)) dut (
      .ui_clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_mode(cfg_mode),
      .cfg_loops(cfg_loops), .ddr_busy(ddr_busy), .wr_start(wr_start),
      .data_req(data_req), .wr_ddr_data(wr_ddr_data), .wr_done(wr_done),
      .rd_start(rd_start), .rd_data_vld(rd_data_vld), .rd_ddr_data(rd_ddr_data),
      .rd_done(rd_done), .busy(busy), .done(done), .error(error), .err_cnt(err_cnt),
      .first_err_beat(first_err_beat), .len_err(len_err), .pass_cnt(pass_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_run(input logic [1:0] m, input logic [15:0] n);
      cfg_mode  = m;
      cfg_loops = n;
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      check("busy_after_start", busy, 1);
      check("done_cleared_on_start", done, 0);
   endtask

   task automatic wait_wr_start();
      int n = 0;
      while (wr_start !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("wr_start_seen", wr_start, 1);
   endtask

   task automatic wait_rd_start();
      int n = 0;
      while (rd_start !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rd_start_seen", rd_start, 1);
   endtask

   task automatic do_write(input int n, input bit finish);
      for (int b = 0; b < n; b++) begin
         mem[b]   = wr_ddr_data;
         data_req = 1'b1;
         @(negedge clk);
      end
      data_req = 1'b0;
      if (finish) begin
         wr_done = 1'b1;
         @(negedge clk);
         wr_done = 1'b0;
      end
   endtask

   task automatic do_read(input int n, input int bad);
      for (int b = 0; b < n; b++) begin
         rd_data_vld = 1'b1;
         rd_ddr_data = mem[b];
         if (b == bad) begin
            rd_ddr_data[0] = ~rd_ddr_data[0];
            check("error_before_bad_beat", error, 0);
         end
         @(negedge clk);
         if (b == bad) check("error_after_bad_beat", error, 1);
      end
      rd_data_vld = 1'b0;
      rd_ddr_data = '0;
      rd_done     = 1'b1;
      @(negedge clk);
      rd_done     = 1'b0;
   endtask

   task automatic run_loop(input int nrd, input int bad);
      wait_wr_start();
      do_write(BL, 1'b1);
      wait_rd_start();
      do_read(nrd, bad);
   endtask

   initial begin
      bit saw;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_wr_start", wr_start, 0);
      check("rst_wr_data", wr_ddr_data, 0);
      check("rst_pass_cnt", pass_cnt, 0);
      rst = 1'b0;
      @(negedge clk);

      // COUNT, two loops, clean loopback
      start_run(2'd0, 16'd2);
      run_loop(BL, -1);
      check("count_beat0", mem[0], '0);
      check("count_beat1", mem[1], {32{8'h01}});
      check("count_beat63", mem[63], {32{8'h3F}});
      check("count_pass_after_1", pass_cnt, 1);
      check("count_busy_mid_run", busy, 1);
      run_loop(BL, -1);
      check("count_done", done, 1);
      check("count_busy_end", busy, 0);
      check("count_error", error, 0);
      check("count_pass_cnt", pass_cnt, 2);

      // COUNT, one loop, read beat 5 bit 0 flipped
      start_run(2'd0, 16'd1);
      check("pass_cleared_on_start", pass_cnt, 0);
      run_loop(BL, 5);
      check("corrupt_err_cnt", err_cnt, 1);
      check("corrupt_first_beat", first_err_beat, 6'd5);
      check("corrupt_pass_cnt", pass_cnt, 0);
      check("corrupt_len_err", len_err, 0);
      check("corrupt_done", done, 1);

      // PRBS31, three loops; start request mid-run must be ignored
      start_run(2'd1, 16'd3);
      check("error_cleared_on_start", error, 0);
      check("err_cnt_cleared_on_start", err_cnt, 0);
      run_loop(BL, -1);
      check("prbs_beat0", mem[0], {8{32'h00000012}});
      cfg_mode  = 2'd0;
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      check("start_ignored_busy", busy, 1);
      check("start_ignored_pass", pass_cnt, 1);
      run_loop(BL, -1);
      run_loop(BL, -1);
      check("prbs_error", error, 0);
      check("prbs_pass_cnt", pass_cnt, 3);
      check("prbs_done", done, 1);

      // WALK1 and INV_COUNT, one loop each
      start_run(2'd2, 16'd1);
      run_loop(BL, -1);
      check("walk_beat0", mem[0], one);
      check("walk_beat63", mem[63], one << 63);
      check("walk_pass", pass_cnt, 1);
      start_run(2'd3, 16'd1);
      run_loop(BL, -1);
      check("inv_beat0", mem[0], '1);
      check("inv_beat2", mem[2], {32{8'hFD}});
      check("inv_error", error, 0);

      // short read burst in loop 1, loop 2 still runs
      start_run(2'd0, 16'd2);
      run_loop(BL - 1, -1);
      check("short_len_err", len_err, 1);
      check("short_error", error, 1);
      check("short_pass_after_1", pass_cnt, 0);
      check("short_err_cnt", err_cnt, 0);
      run_loop(BL, -1);
      check("short_pass_cnt", pass_cnt, 1);
      check("short_done", done, 1);

      // ddr_busy held high in ARB
      ddr_busy = 1'b1;
      start_run(2'd0, 16'd1);
      saw = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (wr_start) saw = 1'b1;
         @(negedge clk);
      end
      check("no_wr_start_while_busy", saw, 0);
      ddr_busy = 1'b0;
      @(negedge clk);
      check("wr_start_after_busy_drop", wr_start, 1);
      @(negedge clk);
      check("wr_start_one_cycle", wr_start, 0);
      do_write(BL, 1'b1);
      wait_rd_start();
      do_read(BL, -1);
      check("busy_run_pass", pass_cnt, 1);

      // async reset in the middle of a write burst
      start_run(2'd0, 16'd1);
      wait_wr_start();
      do_write(20, 1'b0);
      check("mid_write_beat20", wr_ddr_data, {32{8'h14}});
      #1 rst = 1'b1;
      #1;
      check("async_rst_busy", busy, 0);
      check("async_rst_wr_data", wr_ddr_data, 0);
      check("async_rst_pass", pass_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      start_run(2'd0, 16'd1);
      run_loop(BL, -1);
      check("restart_beat1", mem[1], {32{8'h01}});
      check("restart_beat20", mem[20], {32{8'h14}});
      check("restart_pass", pass_cnt, 1);
      check("restart_done", done, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
